dual_port_ram_scan_reader: RTL

//  Read-side companion to the switch-driven dual-port RAM writer. Drives addr_rd and

---
 rtl/dual_port_ram_scan_reader.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/dual_port_ram_scan_reader.sv
// Paced sequential reader for a dual-port RAM: issues addr_rd, captures ram_dout and strobes each word.
// Optional SCAN_CHECKSUM_EN adds an XOR checksum output over each scan pass.
module dual_port_ram_scan_reader #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 3,
   parameter int TICK_COUNT = 0,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  continuous,
   output logic [ADDR_WIDTH-1:0] addr_rd,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [ADDR_WIDTH-1:0] addr_out,
   output logic                  data_valid,
   output logic                  busy,
   output logic                  done
`ifdef SCAN_CHECKSUM_EN
   ,
   output logic [DATA_WIDTH-1:0] checksum
`endif
);

   localparam int PACE_W = (TICK_COUNT > 0) ? $clog2(TICK_COUNT + 1) : 1;
   localparam int LAT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
   localparam logic [PACE_W-1:0]     PACE_LAST = (TICK_COUNT > 0) ? PACE_W'(TICK_COUNT - 1) : '0;
   localparam logic [LAT_W-1:0]      LAT_LAST  = LAT_W'(RD_LATENCY - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DATA, CAPTURE, PACE} state_t;

   state_t                  state, state_n;
   logic [ADDR_WIDTH-1:0]   addr_cnt, addr_cnt_n;
   logic [ADDR_WIDTH-1:0]   addr_rd_n, addr_out_n;
   logic [DATA_WIDTH-1:0]   data_out_n;
   logic                    data_valid_n, done_n;
   logic                    stop_latch, stop_latch_n;
   logic [PACE_W-1:0]       pace_cnt, pace_cnt_n;
   logic [LAT_W-1:0]        lat_cnt, lat_cnt_n;
`ifdef SCAN_CHECKSUM_EN
   logic [DATA_WIDTH-1:0]   checksum_n;
`endif

   assign busy = (state != IDLE);

   always_comb begin
      state_n      = state;
      addr_cnt_n   = addr_cnt;
      addr_rd_n    = addr_rd;
      addr_out_n   = addr_out;
      data_out_n   = data_out;
      data_valid_n = 1'b0;
      done_n       = 1'b0;
      pace_cnt_n   = pace_cnt;
      lat_cnt_n    = lat_cnt;
`ifdef SCAN_CHECKSUM_EN
      checksum_n   = checksum;
`endif
      unique case (state)
         IDLE: begin
            if (start && !stop) begin
               state_n    = ISSUE;
               addr_cnt_n = '0;
`ifdef SCAN_CHECKSUM_EN
               checksum_n = '0;
`endif
            end
         end
         ISSUE: begin
            addr_rd_n = addr_cnt;
            lat_cnt_n = '0;
            state_n   = WAIT_DATA;
         end
         WAIT_DATA: begin
            if (lat_cnt == LAT_LAST) state_n = CAPTURE;
            else                     lat_cnt_n = lat_cnt + 1'b1;
         end
         CAPTURE: begin
            data_out_n   = ram_dout;
            addr_out_n   = addr_cnt;
            data_valid_n = 1'b1;
`ifdef SCAN_CHECKSUM_EN
            // Address 0 starts a fresh pass, so each continuous wrap accumulates from zero.
            checksum_n   = ((addr_cnt == '0) ? '0 : checksum) ^ ram_dout;
`endif
            if (stop_latch || stop) begin
               state_n = IDLE;
            end else if (addr_cnt == ADDR_MAX && !continuous) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end else begin
               addr_cnt_n = addr_cnt + 1'b1;
               pace_cnt_n = '0;
               state_n    = (TICK_COUNT > 0) ? PACE : ISSUE;
            end
         end
         PACE: begin
            if (pace_cnt == PACE_LAST) state_n = ISSUE;
            else                       pace_cnt_n = pace_cnt + 1'b1;
         end
         default: state_n = IDLE;
      endcase

      stop_latch_n = stop_latch;
      if (state != IDLE && stop) stop_latch_n = 1'b1;
      if (state_n == IDLE)       stop_latch_n = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         addr_cnt   <= '0;
         addr_rd    <= '0;
         addr_out   <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         done       <= 1'b0;
         stop_latch <= 1'b0;
         pace_cnt   <= '0;
         lat_cnt    <= '0;
`ifdef SCAN_CHECKSUM_EN
         checksum   <= '0;
`endif
      end else begin
         state      <= state_n;
         addr_cnt   <= addr_cnt_n;
         addr_rd    <= addr_rd_n;
         addr_out   <= addr_out_n;
         data_out   <= data_out_n;
         data_valid <= data_valid_n;
         done       <= done_n;
         stop_latch <= stop_latch_n;
         pace_cnt   <= pace_cnt_n;
         lat_cnt    <= lat_cnt_n;
`ifdef SCAN_CHECKSUM_EN
         checksum   <= checksum_n;
`endif
      end
   end

endmodule
